// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_pkg: shared constants for the memory-mapped UART transmitter.
//   TXDATA_OFS / STATUS_OFS : register byte offsets from BASE_ADDR
//   ST_*                    : bit positions inside the STATUS word
//   uart_state_e            : serialiser FSM states
package mmio_uart_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory bus slice seen by the UART.
//   master : core side (drives strobes/address/write data)
//   slave  : UART side (returns hit flag and read data)
interface mmio_uart_tx_if;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mmio_hit;
    logic [31:0] mem_rdata;

    modport master (
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mmio_hit, mem_rdata
    );

    modport slave (
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mmio_hit, mem_rdata
    );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock circular FIFO.
//   clk, rst          : clock, synchronous active-low reset
//   i_push, i_data    : write request and data
//   i_pop             : read request (ignored when empty)
//   o_data            : head entry (valid while !o_empty)
//   o_full, o_empty   : pointer-compare flags
//   o_count           : occupancy 0..DEPTH
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count   = r_wptr - r_rptr;
    assign o_data    = r_mem[r_rptr[AW-1:0]];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped transmit-only 8N1 UART.
//   clk, rst : clock, synchronous active-low reset
//   bus      : data-bus slave (TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4)
//   tx       : registered serial output, idles high, LSB first
//   tx_busy  : FIFO non-empty or frame in progress
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           tx_busy
);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int          BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [31:0] TX_ADDR   = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0] ST_ADDR   = BASE_ADDR + STATUS_OFS;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // ---------------- bus decode ----------------
    logic w_sel_tx, w_sel_st, w_wr_tx, w_ovf_set, w_ovf_clr;
    logic w_unused;

    assign w_sel_tx     = (bus.mem_addr[31:2] == TX_ADDR[31:2]);
    assign w_sel_st     = (bus.mem_addr[31:2] == ST_ADDR[31:2]);
    assign bus.mmio_hit = w_sel_tx || w_sel_st;
    assign w_wr_tx      = bus.mem_we && w_sel_tx;
    assign w_unused     = &{1'b0, bus.mem_wdata[31:8], bus.mem_addr[1:0]};

    // ---------------- FIFO ----------------
    logic             w_pop, w_full, w_empty;
    logic [7:0]       w_fifo_dout;
    logic [CNT_W-1:0] w_count;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_tx),
        .i_data  (bus.mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ---------------- overflow flag ----------------
    logic r_ovf;

    assign w_ovf_set = w_wr_tx && w_full && !w_pop;
    assign w_ovf_clr = bus.mem_we && w_sel_st && bus.mem_wdata[ST_OVF];

    // Set has priority over a same-edge clear so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (!rst)           r_ovf <= 1'b0;
        else if (w_ovf_set) r_ovf <= 1'b1;
        else if (w_ovf_clr) r_ovf <= 1'b0;
    end

    // ---------------- serialiser FSM ----------------
    uart_state_e       r_state, w_state_n;
    logic [BAUD_W-1:0] r_baud, w_baud_n;
    logic [2:0]        r_bit, w_bit_n;
    logic [7:0]        r_shift, w_shift_n;
    logic              r_tx, w_tx_n;
    logic              w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
        end
    end

    // The next tx level is computed alongside the state so tx comes straight
    // from r_tx with no decode after the flop.
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                w_tx_n   = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_fifo_dout;
                    w_state_n = S_START;
                    w_tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = S_DATA;
                    w_tx_n    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_n = '0;
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
                    end else begin
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                        w_bit_n   = r_bit + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_n = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_fifo_dout;
                        w_state_n = S_START;
                        w_tx_n    = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                        w_tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_baud_n  = '0;
                w_tx_n    = 1'b1;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = !w_empty || (r_state != S_IDLE);

    // ---------------- STATUS readback ----------------
    logic [31:0] w_status;
    logic [3:0]  w_cnt_sat;

    always_comb begin
        if (32'(w_count) > 32'd15) w_cnt_sat = 4'hF;
        else                       w_cnt_sat = 4'(w_count);
        w_status            = '0;
        w_status[ST_FULL]   = w_full;
        w_status[ST_EMPTY]  = w_empty;
        w_status[ST_ACTIVE] = (r_state != S_IDLE);
        w_status[ST_OVF]    = r_ovf;
        w_status[7:4]       = w_cnt_sat;
    end

    assign bus.mem_rdata = (bus.mem_re && w_sel_st) ? w_status : 32'h0;
endmodule
